plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter.sv | 137 +++++++++++++
 tb/tb_plot_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// Three-requester pixel arbiter feeding a VGA adapter: round-robin grants, lockable bursts,
// off-screen clipping with a drop counter. Define PLOT_ARB_CLEAR_PRIORITY_EN to let the clear requester preempt.
module plot_arbiter #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pause,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  ack,
  output logic        plot,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        busy,
  output logic [7:0]  drop_count,
  output logic        dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0] L_X_MAX = 8'(X_MAX);
  localparam logic [6:0] L_Y_MAX = 7'(Y_MAX);

  state_t     r_state;
  logic [1:0] r_owner;
  logic [1:0] r_ptr;

  logic       w_hold_lock;
  logic       w_valid;
  logic [1:0] w_win;
  logic [1:0] w_rr_idx;
  logic [7:0] w_px;
  logic [6:0] w_py;
  logic [2:0] w_pc;
  logic       w_clip;

  // Round-robin pick: the first set request found walking from (p+1) mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] rq, input logic [1:0] p);
    logic [1:0] idx;
    int         c;
    idx = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      c = (int'(p) + k) % 3;
      if (rq[c]) idx = 2'(c);
    end
    return idx;
  endfunction

  always_comb begin
    w_hold_lock = (r_state == ST_HOLD) && lock[r_owner];
    w_rr_idx    = rr_pick(req, r_ptr);
    w_valid     = 1'b0;
    w_win       = 2'd0;
    if (!pause) begin
`ifdef PLOT_ARB_CLEAR_PRIORITY_EN
      if (req[0]) begin
        w_valid = 1'b1;
        w_win   = 2'd0;
      end else if (w_hold_lock) begin
        w_valid = req[r_owner];
        w_win   = r_owner;
      end else if (|req) begin
        w_valid = 1'b1;
        w_win   = w_rr_idx;
      end
`else
      if (w_hold_lock) begin
        w_valid = req[r_owner];
        w_win   = r_owner;
      end else if (|req) begin
        w_valid = 1'b1;
        w_win   = w_rr_idx;
      end
`endif
    end
  end

  assign ack       = w_valid ? 3'(3'b001 << w_win) : 3'b000;
  assign busy      = (|req) || (r_state == ST_HOLD);
  assign dbg_state = r_state;

  // Coordinates only reach the clip check, never the grant decision.
  always_comb begin
    case (w_win)
      2'd1:    begin w_px = req_x[15:8];  w_py = req_y[13:7];  w_pc = req_colour[5:3]; end
      2'd2:    begin w_px = req_x[23:16]; w_py = req_y[20:14]; w_pc = req_colour[8:6]; end
      default: begin w_px = req_x[7:0];   w_py = req_y[6:0];   w_pc = req_colour[2:0]; end
    endcase
    w_clip = (w_px > L_X_MAX) || (w_py > L_Y_MAX);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_owner    <= 2'd0;
      r_ptr      <= 2'd2;
      plot       <= 1'b0;
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'd0;
      drop_count <= 8'd0;
    end else begin
      plot <= 1'b0;
      if (!pause) begin
        if (w_valid) begin
          r_ptr <= w_win;
          if (lock[w_win]) begin
            r_state <= ST_HOLD;
            r_owner <= w_win;
          end else begin
            r_state <= ST_IDLE;
          end
          if (w_clip) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          end else begin
            plot   <= 1'b1;
            x      <= w_px;
            y      <= w_py;
            colour <= w_pc;
          end
        end else if ((r_state == ST_HOLD) && !lock[r_owner]) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter; expected values are hand-computed per vector.
module tb_plot_arbiter;

  logic        clk;
  logic        resetn;
  logic        pause;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  ack;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        busy;
  logic [7:0]  drop_count;
  logic        dbg_state;

  int n_checks;
  int n_pass;

  plot_arbiter #(.X_MAX(159), .Y_MAX(119)) dut (
    .clk(clk), .resetn(resetn), .pause(pause), .req(req), .lock(lock),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .ack(ack), .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // requester i plots at (10+i, 20+i) in colour i+1
  task automatic default_coords();
    for (int i = 0; i < 3; i++) begin
      req_x[8*i +: 8]      = 8'(10 + i);
      req_y[7*i +: 7]      = 7'(20 + i);
      req_colour[3*i +: 3] = 3'(i + 1);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l);
    req  = r;
    lock = l;
    #1;
  endtask

  initial begin
    logic [2:0] exp_hold;
    n_checks = 0;
    n_pass   = 0;
    resetn = 1'b0;
    pause  = 1'b0;
    req    = 3'b000;
    lock   = 3'b000;
    default_coords();
    #1;
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_xyc", {x, y, colour}, 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // round-robin across all three requesters
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 3'b000);
      chk("rr_ack", 32'(ack), 32'(3'b001 << (i % 3)));
      tick();
      chk("rr_plot", 32'(plot), 32'd1);
      chk("rr_x", 32'(x), 32'(10 + (i % 3)));
    end
    drive(3'b000, 3'b000);
    chk("idle_ack", 32'(ack), 32'd0);
    tick();
    chk("idle_plot", 32'(plot), 32'd0);
    chk("idle_hold_x", 32'(x), 32'd12);

    // locked burst from requester 1 while requester 2 waits
    for (int i = 0; i < 4; i++) begin
      drive(3'b110, 3'b010);
      chk("lock_ack", 32'(ack), 32'b010);
      tick();
    end
    chk("lock_state", 32'(dbg_state), 32'd1);
    drive(3'b000, 3'b010);
    chk("lock_gap_ack", 32'(ack), 32'd0);
    chk("lock_gap_busy", 32'(busy), 32'd1);
    tick();
    drive(3'b110, 3'b000);
    chk("unlock_ack", 32'(ack), 32'b100);
    tick();
    chk("unlock_state", 32'(dbg_state), 32'd0);

    // clipping boundaries, then drop counter saturation
    req_x[23:16] = 8'd160; req_y[20:14] = 7'd5;
    drive(3'b100, 3'b000);
    chk("clip_x_ack", 32'(ack), 32'b100);
    tick();
    chk("clip_x_plot", 32'(plot), 32'd0);
    chk("clip_x_hold", 32'(x), 32'd12);
    chk("clip_x_drop", 32'(drop_count), 32'd1);
    req_x[23:16] = 8'd159; req_y[20:14] = 7'd120;
    drive(3'b100, 3'b000);
    tick();
    chk("clip_y_plot", 32'(plot), 32'd0);
    chk("clip_y_drop", 32'(drop_count), 32'd2);
    req_y[20:14] = 7'd119;
    drive(3'b100, 3'b000);
    tick();
    chk("edge_plot", 32'(plot), 32'd1);
    chk("edge_xy", {x, y}, {8'd159, 7'd119});
    chk("edge_drop", 32'(drop_count), 32'd2);
    req_x[23:16] = 8'd160; req_y[20:14] = 7'd5;
    for (int i = 0; i < 300; i++) begin
      drive(3'b100, 3'b000);
      tick();
    end
    chk("sat_drop", 32'(drop_count), 32'd255);
    chk("sat_plot", 32'(plot), 32'd0);
    default_coords();

    // pause freezes the pointer mid-stream
    drive(3'b111, 3'b000);
    chk("pre_pause_ack0", 32'(ack), 32'b001);
    tick();
    drive(3'b111, 3'b000);
    chk("pre_pause_ack1", 32'(ack), 32'b010);
    tick();
    pause = 1'b1;
    drive(3'b111, 3'b000);
    chk("pause_ack", 32'(ack), 32'd0);
    chk("pause_busy", 32'(busy), 32'd1);
    tick();
    chk("pause_plot", 32'(plot), 32'd0);
    chk("pause_hold_x", 32'(x), 32'd11);
    tick();
    chk("pause_ack2", 32'(ack), 32'd0);
    pause = 1'b0;
    drive(3'b111, 3'b000);
    chk("resume_ack", 32'(ack), 32'b100);
    tick();
    chk("resume_x", 32'(x), 32'd12);

    // reset in the middle of a requester-2 burst
    drive(3'b100, 3'b100);
    chk("pre_rst_ack", 32'(ack), 32'b100);
    tick();
    chk("pre_rst_state", 32'(dbg_state), 32'd1);
    drive(3'b000, 3'b100);
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_xyc", {x, y, colour}, 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    tick();
    resetn = 1'b1;
    drive(3'b110, 3'b000);
    chk("post_rst_ack", 32'(ack), 32'b010);
    tick();

    // clear requester arriving during a requester-2 burst
    drive(3'b100, 3'b100);
    chk("prio_start_ack", 32'(ack), 32'b100);
    tick();
`ifdef PLOT_ARB_CLEAR_PRIORITY_EN
    exp_hold = 3'b001;
`else
    exp_hold = 3'b100;
`endif
    for (int i = 0; i < 2; i++) begin
      drive(3'b101, 3'b100);
      chk("prio_hold_ack", 32'(ack), 32'(exp_hold));
      tick();
    end
    drive(3'b101, 3'b000);
    chk("prio_release_ack", 32'(ack), 32'b001);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
